// File: rtl/rf_arb_pkg.sv
// Shared types and sizing for the register-file access arbiter.
package rf_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef enum logic {ST_INIT, ST_RUN} rf_arb_state_t;

  typedef enum logic {CL_A, CL_B} client_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] radd1;
    logic [DEF_ADDR_W-1:0] radd2;
    logic [DEF_ADDR_W-1:0] wadd;
    logic [DEF_DATA_W-1:0] wdata;
  } rf_req_t;

endpackage

// File: rtl/rf_access_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the most recently accepted client loses the next tie.
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  client_t last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == CL_B) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept_i && gnt_o[0]) begin
      last_d = CL_A;
    end else if (accept_i && gnt_o[1]) begin
      last_d = CL_B;
    end
  end

  // B counts as last winner after reset so A takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CL_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares a 1W/2R register file between two valid/ready clients after an
// optional post-reset sweep that zeroes every writable register.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic              b_valid,
  output logic              a_ready,
  output logic              b_ready,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_radd1,
  input  logic [ADDR_W-1:0] a_radd2,
  input  logic [ADDR_W-1:0] b_radd1,
  input  logic [ADDR_W-1:0] b_radd2,
  input  logic [ADDR_W-1:0] a_wadd,
  input  logic [ADDR_W-1:0] b_wadd,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_rsp_valid,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [DATA_W-1:0] rsp_rdata2,
  output logic              init_done,
  output logic              rf_rfwrite,
  output logic [ADDR_W-1:0] rf_radd1,
  output logic [ADDR_W-1:0] rf_radd2,
  output logic [ADDR_W-1:0] rf_wadd,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NREGS - 1);

  rf_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q;
  logic              a_rsp_q, b_rsp_q;
  logic [DATA_W-1:0] rdata1_q, rdata2_q;

  logic              run;
  logic [1:0]        gnt;
  logic              xfer;
  rf_req_t           req_a, req_b, sel;

  assign req_a = {a_we, a_radd1, a_radd2, a_wadd, a_wdata};
  assign req_b = {b_we, b_radd1, b_radd2, b_wadd, b_wdata};

  // Gating with rst_n keeps every combinational output low while reset is held
  assign run  = rst_n && (state_q == ST_RUN);
  assign xfer = a_ready | b_ready;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({b_valid & run, a_valid & run}),
    .accept_i (xfer),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_INIT;
      end else begin
        state_q <= ST_RUN;
      end
      cnt_q       <= ADDR_W'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    rf_rfwrite = 1'b0;
    rf_radd1   = '0;
    rf_radd2   = '0;
    rf_wadd    = '0;
    rf_wdata   = '0;
    sel        = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        rf_rfwrite = 1'b1;
        rf_wadd    = cnt_q;
      end else begin
        a_ready = gnt[0];
        b_ready = gnt[1];
        if (gnt[0]) begin
          sel = req_a;
        end else if (gnt[1]) begin
          sel = req_b;
        end
        // x0 is read-only: the transfer completes but the write is dropped
        rf_rfwrite = sel.we && (sel.wadd != '0);
        rf_radd1   = sel.radd1;
        rf_radd2   = sel.radd2;
        rf_wadd    = sel.wadd;
        rf_wdata   = sel.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_q  <= 1'b0;
      b_rsp_q  <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      a_rsp_q <= a_ready;
      b_rsp_q <= b_ready;
      if (xfer) begin
        rdata1_q <= rf_rdata1;
        rdata2_q <= rf_rdata2;
      end
    end
  end

  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  assign rsp_rdata1  = rdata1_q;
  assign rsp_rdata2  = rdata2_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: register-file stand-in, behavioural model and directed/random stimulus.
module tb_rf_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_valid, b_valid, a_we, b_we;
  logic [AW-1:0] a_radd1, a_radd2, b_radd1, b_radd2, a_wadd, b_wadd;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, init_done;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2;
  logic          rf_rfwrite;
  logic [AW-1:0] rf_radd1, rf_radd2, rf_wadd;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_we(a_we), .b_we(b_we),
    .a_radd1(a_radd1), .a_radd2(a_radd2), .b_radd1(b_radd1), .b_radd2(b_radd2),
    .a_wadd(a_wadd), .b_wadd(b_wadd), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2), .init_done(init_done),
    .rf_rfwrite(rf_rfwrite), .rf_radd1(rf_radd1), .rf_radd2(rf_radd2),
    .rf_wadd(rf_wadd), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Second instance without the clearing sweep
  logic          rst0_n, b0_valid, b0_we, z_bit;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_data;
  logic          a0_ready, b0_ready, a0_rsp_valid, b0_rsp_valid, init0_done, rf0_rfwrite;
  logic [DW-1:0] rsp0_rdata1, rsp0_rdata2, rf0_wdata;
  logic [AW-1:0] rf0_radd1, rf0_radd2, rf0_wadd;

  rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n),
    .a_valid(z_bit), .b_valid(b0_valid), .a_ready(a0_ready), .b_ready(b0_ready),
    .a_we(z_bit), .b_we(b0_we),
    .a_radd1(z_addr), .a_radd2(z_addr), .b_radd1(z_addr), .b_radd2(z_addr),
    .a_wadd(z_addr), .b_wadd(z_addr), .a_wdata(z_data), .b_wdata(z_data),
    .a_rsp_valid(a0_rsp_valid), .b_rsp_valid(b0_rsp_valid),
    .rsp_rdata1(rsp0_rdata1), .rsp_rdata2(rsp0_rdata2), .init_done(init0_done),
    .rf_rfwrite(rf0_rfwrite), .rf_radd1(rf0_radd1), .rf_radd2(rf0_radd2),
    .rf_wadd(rf0_wadd), .rf_wdata(rf0_wdata), .rf_rdata1(z_data), .rf_rdata2(z_data)
  );

  // Register file stand-in: writes on the edge, combinational reads, x0 reads zero
  logic [DW-1:0] rf_mem [32];
  logic          scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= $urandom;
    end else if (rf_rfwrite && rf_wadd != '0) begin
      rf_mem[rf_wadd] <= rf_wdata;
    end
  end
  assign rf_rdata1 = (rf_radd1 == '0) ? '0 : rf_mem[rf_radd1];
  assign rf_rdata2 = (rf_radd2 == '0) ? '0 : rf_mem[rf_radd2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: sweep progress, register contents, last winner, pending response
  int            m_sweep;
  logic          m_last_b;
  logic [DW-1:0] m_mem [32];
  logic          m_rspa, m_rspb, m_init;
  logic [DW-1:0] m_r1, m_r2;
  int            win;
  logic          e_ra, e_rb, e_w;
  logic [AW-1:0] e_a1, e_a2, e_wa;
  logic [DW-1:0] e_wd;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst a_ready", a_ready, 0);
      chk("rst b_ready", b_ready, 0);
      chk("rst a_rsp_valid", a_rsp_valid, 0);
      chk("rst b_rsp_valid", b_rsp_valid, 0);
      chk("rst rsp_rdata1", rsp_rdata1, 0);
      chk("rst rsp_rdata2", rsp_rdata2, 0);
      chk("rst init_done", init_done, 0);
      chk("rst rf_rfwrite", rf_rfwrite, 0);
      chk("rst rf_wadd", rf_wadd, 0);
      chk("rst rf_wdata", rf_wdata, 0);
      m_sweep = 0; m_last_b = 1'b1; m_rspa = 0; m_rspb = 0;
      m_r1 = '0; m_r2 = '0; m_init = 0;
    end else begin
      chk("m a_rsp_valid", a_rsp_valid, m_rspa);
      chk("m b_rsp_valid", b_rsp_valid, m_rspb);
      chk("m rsp_rdata1", rsp_rdata1, m_r1);
      chk("m rsp_rdata2", rsp_rdata2, m_r2);
      chk("m init_done", init_done, m_init);
      win = 0; e_ra = 0; e_rb = 0; e_w = 0;
      e_a1 = '0; e_a2 = '0; e_wa = '0; e_wd = '0;
      if (m_sweep < 31) begin
        e_w  = 1'b1;
        e_wa = AW'(m_sweep + 1);
      end else begin
        if (a_valid && b_valid) win = m_last_b ? 1 : 2;
        else if (a_valid)       win = 1;
        else if (b_valid)       win = 2;
        if (win == 1) begin
          e_ra = 1; e_a1 = a_radd1; e_a2 = a_radd2; e_wa = a_wadd; e_wd = a_wdata;
          e_w = a_we && (a_wadd != 0);
        end else if (win == 2) begin
          e_rb = 1; e_a1 = b_radd1; e_a2 = b_radd2; e_wa = b_wadd; e_wd = b_wdata;
          e_w = b_we && (b_wadd != 0);
        end
      end
      chk("m a_ready", a_ready, e_ra);
      chk("m b_ready", b_ready, e_rb);
      chk("m rf_rfwrite", rf_rfwrite, e_w);
      chk("m rf_radd1", rf_radd1, e_a1);
      chk("m rf_radd2", rf_radd2, e_a2);
      chk("m rf_wadd", rf_wadd, e_wa);
      chk("m rf_wdata", rf_wdata, e_wd);
      if (m_sweep < 31) begin
        m_mem[m_sweep + 1] = '0;
        m_sweep++;
        m_rspa = 0; m_rspb = 0;
        m_init = (m_sweep == 31);
      end else begin
        m_rspa = (win == 1);
        m_rspb = (win == 2);
        if (win != 0) begin
          m_r1 = rd(e_a1);
          m_r2 = rd(e_a2);
          if (e_w) m_mem[e_wa] = e_wd;
          m_last_b = (win == 2);
        end
        m_init = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    a_valid = ($urandom_range(0, 3) != 0);
    b_valid = ($urandom_range(0, 3) != 0);
    a_we    = $urandom_range(0, 1);
    b_we    = $urandom_range(0, 1);
    a_radd1 = AW'($urandom_range(0, 31)); a_radd2 = AW'($urandom_range(0, 31));
    b_radd1 = AW'($urandom_range(0, 31)); b_radd2 = AW'($urandom_range(0, 31));
    a_wadd  = AW'($urandom_range(0, 31)); b_wadd  = AW'($urandom_range(0, 31));
    a_wdata = $urandom; b_wdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; rst0_n = 0; scramble = 1;
    z_bit = 0; z_addr = '0; z_data = '0; b0_valid = 1; b0_we = 0;
    a_valid = 1; a_we = 0; a_radd1 = '0; a_radd2 = '0; a_wadd = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_radd1 = '0; b_radd2 = '0; b_wadd = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    scramble = 0;
    chk("reset a_ready", a_ready, 0);
    chk("reset rf_rfwrite", rf_rfwrite, 0);
    chk("c0 reset b_ready", b0_ready, 0);

    rst_n = 1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk("sweep rf_rfwrite", rf_rfwrite, 1);
      chk("sweep rf_wadd", rf_wadd, k);
      chk("sweep rf_wdata", rf_wdata, 0);
      chk("sweep a_ready", a_ready, 0);
    end
    @(negedge clk);
    chk("init_done rise", init_done, 1);
    chk("a_ready at init", a_ready, 1);

    step();
    a_we = 1; a_radd1 = '0; a_radd2 = 5'd2; a_wadd = 5'd2; a_wdata = 32'd9;
    step();
    chk("rmw a_rsp_valid", a_rsp_valid, 1);
    chk("rmw pre-write rdata2", rsp_rdata2, 0);
    a_we = 0;
    step();
    chk("readback x2", rsp_rdata2, 9);
    chk("readback a_rsp_valid", a_rsp_valid, 1);
    a_valid = 0;
    step();
    chk("a_rsp_valid one cycle", a_rsp_valid, 0);
    chk("rsp_rdata2 hold", rsp_rdata2, 9);

    b_valid = 1; b_we = 1; b_wadd = '0; b_wdata = 32'd123; b_radd1 = '0; b_radd2 = '0;
    @(negedge clk);
    chk("x0 write b_ready", b_ready, 1);
    chk("x0 write suppressed", rf_rfwrite, 0);
    step();
    chk("b_rsp_valid", b_rsp_valid, 1);

    a_valid = 1; a_we = 1; a_wadd = 5'd20; a_wdata = 32'd55; a_radd1 = '0; a_radd2 = '0;
    b_valid = 1; b_we = 1; b_wadd = 5'd26; b_wdata = 32'd44;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alternate a_ready", a_ready, (k % 2 == 0));
      chk("alternate b_ready", b_ready, (k % 2 == 1));
      step();
    end
    b_valid = 0; a_we = 0; a_radd1 = 5'd20; a_radd2 = 5'd26;
    step();
    chk("read x20", rsp_rdata1, 55);
    chk("read x26", rsp_rdata2, 44);
    a_radd1 = '0;
    step();
    chk("read x0", rsp_rdata1, 0);
    a_valid = 0;

    repeat (400) begin
      rand_inputs();
      step();
    end

    a_valid = 1; b_valid = 0; a_we = 1; a_wadd = 5'd5; a_wdata = 32'd77;
    a_radd1 = 5'd5; a_radd2 = '0;
    step();
    a_we = 0;
    step();
    chk("read x5", rsp_rdata1, 77);
    rst_n = 0;
    #1;
    chk("async rst a_ready", a_ready, 0);
    chk("async rst rsp_rdata1", rsp_rdata1, 0);
    chk("async rst a_rsp_valid", a_rsp_valid, 0);
    chk("async rst init_done", init_done, 0);
    chk("async rst rf_radd1", rf_radd1, 0);
    repeat (2) @(posedge clk);
    #1;
    a_we = 0; a_radd1 = '0;
    rst_n = 1;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    chk("mid-sweep wadd", rf_wadd, 15);
    #1;
    rst_n = 0;
    #1;
    chk("mid-sweep rst rf_rfwrite", rf_rfwrite, 0);
    chk("mid-sweep rst rf_wadd", rf_wadd, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("sweep restart wadd", rf_wadd, 1);
    repeat (32) step();
    repeat (150) begin
      rand_inputs();
      step();
    end

    b0_valid = 1; b0_we = 0;
    rst0_n = 1;
    @(negedge clk);
    chk("c0 b_ready at first edge", b0_ready, 1);
    chk("c0 init_done low", init0_done, 0);
    chk("c0 no sweep write", rf0_rfwrite, 0);
    step();
    chk("c0 init_done high", init0_done, 1);
    chk("c0 b_rsp_valid", b0_rsp_valid, 1);
    b0_valid = 0;
    @(negedge clk);
    chk("c0 idle rf_rfwrite", rf0_rfwrite, 0);
    chk("c0 idle rf_wadd", rf0_wadd, 0);
    chk("c0 idle b_ready", b0_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
